// File: rtl/serial_seq.sv
// Word-level sequencer for a shared bit-serial execution unit: accepts a parallel
// request, streams both operands LSB first, and reassembles the serial result.
module serial_seq #(
    parameter int WIDTH = 8,
    parameter int OPW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [OPW-1:0]   req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             ser_clr,
    output logic             ser_a,
    output logic             ser_b,
    output logic [OPW-1:0]   ser_op,
    input  logic             ser_y
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        RESP  = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic [OPW-1:0]   op_r;
    logic [CW-1:0]    cnt_r;
    logic             accept_s;
    logic             last_s;

    assign accept_s = (state_r == IDLE) && req_valid;
    assign last_s   = (cnt_r == CNT_LAST);

    // Outputs decode directly from registered state; the shift registers are
    // zero-filled by the end of a word, and the state gate keeps the unit
    // inputs quiet while it is held cleared.
    assign req_ready = (state_r == IDLE);
    assign rsp_valid = (state_r == RESP);
    assign ser_clr   = (state_r != SHIFT);
    assign ser_a     = (state_r == SHIFT) & a_sh_r[0];
    assign ser_b     = (state_r == SHIFT) & b_sh_r[0];
    assign ser_op    = op_r;
    assign rsp_data  = res_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = RESP;
                end else begin
                    state_s = SHIFT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand shifters, bit counter and result assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r <= '0;
            b_sh_r <= '0;
            res_r  <= '0;
            op_r   <= '0;
            cnt_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_sh_r <= req_a;
                        b_sh_r <= req_b;
                        op_r   <= req_op;
                        cnt_r  <= '0;
                        res_r  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_r  <= {ser_y, res_r[WIDTH-1:1]};
                    // Hold at the last index so the counter never wraps mid-word.
                    if (!last_s) begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/serial_seq.md
# serial_seq

Word-level sequencer for the bit-serial datapath units (incrementer, adder and similar) in the serial CPU. Accepts a parallel operand request over a valid/ready handshake. Holds the serial unit cleared between words, then streams both operands into it LSB first for WIDTH cycles and reassembles the serial result into a parallel word. Presents that word on a response handshake with backpressure. It sits between the CPU control/register file and one shared serial execution unit.

## Interface
Parameters:
- WIDTH, 8, operand/result word width in bits (≥2)
- OPW, 2, width of the opcode forwarded to the serial unit

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B (ignored by single-operand units)
- req_op  in  OPW  opcode for serial unit
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer takes result
- rsp_data  out  WIDTH  assembled result
- ser_clr  out  1  clear serial unit internal state (carry), active-high
- ser_a  out  1  current bit of A
- ser_b  out  1  current bit of B
- ser_op  out  OPW  opcode, stable for whole word
- ser_y  in  1  serial unit result bit, combinational from current ser_a/ser_b and unit state

## Operation
- States: IDLE, SHIFT, RESP.
- IDLE: req_ready=1, ser_clr=1, ser_a=ser_b=0. On req_valid&&req_ready: latch req_a, req_b, req_op into shift/op registers, clear bit counter, clear result register → SHIFT.
- SHIFT: ser_clr=0, ser_a=a_sh[0], ser_b=b_sh[0], ser_op=latched op. Each cycle: a_sh, b_sh shift right (zero fill). res <= {ser_y, res[WIDTH-1:1]}. cnt <= cnt+1. When cnt==WIDTH-1 → RESP.
- Counter width is clog2(WIDTH). It never wraps inside a word.
- RESP: rsp_valid=1, rsp_data=res, ser_clr=1, ser_a=ser_b=0, req_ready=0. On rsp_ready → IDLE. While rsp_ready=0, hold rsp_data and rsp_valid stable indefinitely.
- Arithmetic is whatever the serial unit does, modulo 2^WIDTH. Carry out of MSB is discarded, e.g. inc of all-ones gives 0.
- req_valid outside IDLE is ignored. No queuing; requester must hold until req_ready.
- rsp_data is a registered output. Outside RESP it shows the last assembled value (0 after reset) and is not meaningful.
- ser_op holds the last latched opcode outside SHIFT (0 after reset).

## Timing
- Reset (async, immediate on rst high): state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, ser_clr=1, ser_a=0, ser_b=0, ser_op=0, cnt=0.
- Reset mid-SHIFT or mid-RESP aborts the word. The result is discarded and no rsp_valid is produced for it.
- Latency: request accepted at edge k. ser_a/ser_b carry bit i during cycle k+1+i, i=0..WIDTH-1. rsp_valid is high from cycle k+1+WIDTH.
- Minimum issue interval: WIDTH+2 cycles (RESP with rsp_ready=1 for 1 cycle, then 1 IDLE cycle).
- ser_clr is high for at least one full cycle before bit 0 of every word.
- ser_y is sampled on the same edge that ends the cycle in which the matching bit is driven. No pipeline delay is assumed.

## Test plan
- WIDTH=8 with inc unit, req_a=0x7F, rsp_ready=1 → rsp_valid exactly 9 cycles after accept edge, rsp_data=0x80, ser_clr high in cycle before first bit.
- Inc with req_a=0xFF → rsp_data=0x00 (wrap, carry discarded). Inc with req_a=0x00 → 0x01.
- Adder model, req_a=0xA5, req_b=0x3C → rsp_data=0xE1. rsp_ready held low 3 cycles → rsp_valid/rsp_data stable, req_ready=0 throughout.
- Back-to-back: req_valid held high with two requests (0x10, 0x20 inc) → results 0x11 then 0x21, second accept exactly 1 cycle after first response handshake, no overlap.
- rst pulsed high during SHIFT at bit 4 → all outputs at reset values immediately, no rsp_valid. A fresh request 0x41 inc then yields 0x42.
- req_valid toggled during SHIFT/RESP with changing req_a → ignored, in-flight result unaffected.
